// File: rtl/mac_pkg.sv
// Shared definitions for the SD4 MAC accumulator stage: default widths,
// FSM state encoding and the default-width saturation limits.
package mac_pkg;

    localparam int IN_W_DEF  = 20;
    localparam int ACC_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/mac_accumulator_if.sv
// Beat input and result output handshake bundle of the MAC accumulator.
// The slave modport is the accumulator; the master modport is its environment.
interface mac_accumulator_if
    import mac_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = 9
);

    logic             in_valid;
    logic             in_last;
    logic [IN_W-1:0]  signed_sum;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] term_cnt;
    logic             ovf;
    logic             forced_last;

    modport slave (
        input  in_valid, in_last, signed_sum, out_ready,
        output in_ready, out_valid, acc_out, term_cnt, ovf, forced_last
    );

    modport master (
        output in_valid, in_last, signed_sum, out_ready,
        input  in_ready, out_valid, acc_out, term_cnt, ovf, forced_last
    );

endinterface

// File: rtl/mac_sat_add.sv
// Combinational signed accumulate step with overflow detection.
// Defining MAC_ACC_SAT_EN clamps an overflowing sum; otherwise it wraps.
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [IN_W-1:0]  addend,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W:0] wide;

    // One guard bit: its disagreement with the ACC_W sign bit marks overflow,
    // and the guard bit itself carries the sign of the true sum.
    assign wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-IN_W){addend[IN_W-1]}}, addend};
    assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];

`ifdef MAC_ACC_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    always_comb begin
        sum = wide[ACC_W-1:0];
        if (ovf) begin
            sum = wide[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Stage 4 of the SD4 MAC pipeline: accumulates a run of partial sums and
// presents the result on a valid/ready port. MAC_ACC_SAT_EN selects clamping.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int IN_W      = IN_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = $clog2(MAX_TERMS) + 1
) (
    input logic              clk,
    input logic              rst,
    mac_accumulator_if.slave bus
);

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_r;
    logic             forced_r;
    logic             accept;
    logic             close_max;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    assign accept    = bus.in_valid && (state != HOLD);
    assign cnt_inc   = cnt + CNT_W'(1);
    assign close_max = (cnt_inc == CNT_W'(MAX_TERMS));

    mac_sat_add #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_add (
        .acc    (acc),
        .addend (bus.signed_sum),
        .sum    (add_sum),
        .ovf    (add_ovf)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = bus.in_last ? HOLD : ACCUM;
            ACCUM:   if (accept && (bus.in_last || close_max)) state_nxt = HOLD;
            HOLD:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // The first beat of a run overwrites the accumulator, so no clear is needed
    // between runs; ovf is sticky within a run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            cnt      <= '0;
            ovf_r    <= 1'b0;
            forced_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc      <= {{(ACC_W-IN_W){bus.signed_sum[IN_W-1]}}, bus.signed_sum};
                        cnt      <= CNT_W'(1);
                        ovf_r    <= 1'b0;
                        forced_r <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc      <= add_sum;
                        cnt      <= cnt_inc;
                        ovf_r    <= ovf_r | add_ovf;
                        forced_r <= close_max && !bus.in_last;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) forced_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state != HOLD);
    assign bus.out_valid   = (state == HOLD);
    assign bus.acc_out     = acc;
    assign bus.term_cnt    = cnt;
    assign bus.ovf         = ovf_r;
    assign bus.forced_last = forced_r;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed scoreboard bench for mac_accumulator: a 32-bit instance for the
// run/handshake behaviour and a 21-bit instance for overflow (MAC_ACC_SAT_EN aware).
module tb_mac_accumulator;

    localparam int IN_W      = 20;
    localparam int ACC_W     = 32;
    localparam int MAX_TERMS = 256;
    localparam int CNT_W     = 9;
    localparam int NARROW_W  = 21;

    typedef struct {
        longint acc;
        int     cnt;
        bit     ovf;
        bit     forced;
    } result_t;

    result_t expQ[$];

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    longint modelAcc = 0;
    int     modelCnt = 0;
    bit     modelOvf = 1'b0;

    always #5 clk = ~clk;

    mac_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();
    mac_accumulator_if #(.IN_W(IN_W), .ACC_W(NARROW_W), .CNT_W(CNT_W)) bus21 ();

    mac_accumulator #(
        .IN_W      (IN_W),
        .ACC_W     (ACC_W),
        .MAX_TERMS (MAX_TERMS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mac_accumulator #(
        .IN_W      (IN_W),
        .ACC_W     (NARROW_W),
        .MAX_TERMS (MAX_TERMS),
        .CNT_W     (CNT_W)
    ) dut21 (
        .clk (clk),
        .rst (rst),
        .bus (bus21)
    );

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference accumulate step done with plain integer range arithmetic.
    function automatic longint modelStep(input int w, input longint a, input longint b, output bit o);
        longint one = 1;
        longint hi  = (one << (w - 1)) - 1;
        longint lo  = -hi - 1;
        longint t   = a + b;
        o = (t > hi) || (t < lo);
`ifdef MAC_ACC_SAT_EN
        if (t > hi) t = hi;
        else if (t < lo) t = lo;
`else
        if (t > hi) t = t - (one << w);
        else if (t < lo) t = t + (one << w);
`endif
        return t;
    endfunction

    task automatic checkReset(input string tag);
        checkVal({tag, "_acc_out"},     {32'd0, bus.acc_out}, 64'd0);
        checkVal({tag, "_term_cnt"},    {55'd0, bus.term_cnt}, 64'd0);
        checkVal({tag, "_ovf"},         {63'd0, bus.ovf}, 64'd0);
        checkVal({tag, "_forced_last"}, {63'd0, bus.forced_last}, 64'd0);
        checkVal({tag, "_out_valid"},   {63'd0, bus.out_valid}, 64'd0);
        checkVal({tag, "_in_ready"},    {63'd0, bus.in_ready}, 64'd1);
    endtask

    // Called just after a negedge; returns just after a later negedge.
    task automatic applyStimulus(input longint value, input bit last);
        int waits = 0;
        bit o;
        bus.in_valid   = 1'b1;
        bus.signed_sum = IN_W'(value);
        bus.in_last    = last;
        while (bus.in_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 20) checkVal("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (modelCnt == 0) begin
            modelAcc = value;
            modelOvf = 1'b0;
        end else begin
            modelAcc = modelStep(ACC_W, modelAcc, value, o);
            modelOvf = modelOvf | o;
        end
        modelCnt++;
        if (last || modelCnt == MAX_TERMS) begin
            expQ.push_back('{acc: modelAcc, cnt: modelCnt, ovf: modelOvf,
                             forced: (!last && modelCnt == MAX_TERMS)});
            modelCnt = 0;
        end
    endtask

    task automatic checkOutput(input int holdCycles);
        int               waits = 0;
        result_t          e;
        logic [ACC_W-1:0] ea;
        while (bus.out_valid !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        checkVal("out_latency", 64'(waits), 64'd0);
        checkVal("scoreboard_depth", 64'(expQ.size()), 64'd1);
        if (expQ.size() == 0) return;
        e  = expQ.pop_front();
        ea = ACC_W'(e.acc);
        checkVal("acc_out",     {32'd0, bus.acc_out}, {32'd0, ea});
        checkVal("term_cnt",    {55'd0, bus.term_cnt}, 64'(e.cnt));
        checkVal("ovf",         {63'd0, bus.ovf}, {63'd0, e.ovf});
        checkVal("forced_last", {63'd0, bus.forced_last}, {63'd0, e.forced});
        repeat (holdCycles) begin
            @(posedge clk);
            @(negedge clk);
            checkVal("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
            checkVal("hold_in_ready",  {63'd0, bus.in_ready}, 64'd0);
            checkVal("hold_acc_out",   {32'd0, bus.acc_out}, {32'd0, ea});
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkVal("out_valid_drop", {63'd0, bus.out_valid}, 64'd0);
        checkVal("idle_in_ready",  {63'd0, bus.in_ready}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired before the summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        longint na;
        bit     no;
        bit     o;
        logic [NARROW_W-1:0] nexp;

        rst = 1'b0;
        bus.in_valid = 1'b0;   bus.in_last = 1'b0;   bus.signed_sum = '0;   bus.out_ready = 1'b0;
        bus21.in_valid = 1'b0; bus21.in_last = 1'b0; bus21.signed_sum = '0; bus21.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkReset("reset");
        rst = 1'b1;
        @(negedge clk);

        applyStimulus(5, 1'b0);
        applyStimulus(-3, 1'b0);
        applyStimulus(10, 1'b1);
        checkOutput(0);

        applyStimulus(-524288, 1'b1);
        checkOutput(0);

        for (int i = 0; i < MAX_TERMS; i++) applyStimulus(1, 1'b0);
        bus.in_valid   = 1'b1;
        bus.signed_sum = IN_W'(1);
        bus.in_last    = 1'b1;
        checkOutput(4);
        applyStimulus(1, 1'b1);
        checkOutput(0);

        na = 0;
        no = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus21.in_valid   = 1'b1;
            bus21.signed_sum = 20'h7FFFF;
            bus21.in_last    = (i == 2);
            if (i == 0) na = 524287;
            else begin
                na = modelStep(NARROW_W, na, 524287, o);
                no = no | o;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus21.in_valid = 1'b0;
        bus21.in_last  = 1'b0;
        nexp = NARROW_W'(na);
        checkVal("narrow_out_valid", {63'd0, bus21.out_valid}, 64'd1);
        checkVal("narrow_acc_out",   {43'd0, bus21.acc_out}, {43'd0, nexp});
        checkVal("narrow_ovf",       {63'd0, bus21.ovf}, {63'd0, no});
        checkVal("narrow_term_cnt",  {55'd0, bus21.term_cnt}, 64'd3);
        bus21.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus21.out_ready = 1'b0;
        checkVal("narrow_valid_drop", {63'd0, bus21.out_valid}, 64'd0);

        applyStimulus(4, 1'b0);
        applyStimulus(9, 1'b0);
        rst = 1'b0;
        #1;
        checkReset("midrun_reset");
        @(negedge clk);
        rst = 1'b1;
        modelCnt = 0;
        @(negedge clk);
        checkVal("post_reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        applyStimulus(7, 1'b1);
        checkOutput(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
